// File: rtl/oldland_dbg_uart_bridge.sv
// UART-to-debug-mailbox bridge.
// Collects a 9-byte command frame (cmd, addr LE, data LE), writes it into
// mailbox words 0/1/2, runs one req/ack handshake with the debug controller,
// then streams mailbox word 3 back out as four little-endian bytes.
module oldland_dbg_uart_bridge #(
    parameter int unsigned RX_TIMEOUT = 100000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    output logic [7:0]  tx_data_o,
    output logic        tx_valid_o,
    input  logic        tx_ready_i,
    output logic [1:0]  dbg_addr_o,
    output logic [31:0] dbg_din_o,
    input  logic [31:0] dbg_dout_i,
    output logic        dbg_wr_en_o,
    output logic        dbg_req_o,
    input  logic        dbg_ack_i,
    output logic        busy_o,
    output logic        overrun_o
);

    localparam int TO_W = $clog2(RX_TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(RX_TIMEOUT - 1);

    // WR_DATA is the cycle in which the word-2 write is visible, so that the
    // request can only rise once all three mailbox writes have completed.
    typedef enum logic [3:0] {
        S_RX_CMD,
        S_RX_ADDR,
        S_RX_DATA,
        S_WR_DATA,
        S_REQ,
        S_WAIT_ACK_HI,
        S_WAIT_ACK_LO,
        S_RD_RESULT,
        S_TX
    } state_t;

    state_t          state_q;
    logic [1:0]      byte_cnt_q;
    logic [TO_W-1:0] to_cnt_q;
    logic [31:0]     word_q;
    logic [31:0]     result_q;
    logic [7:0]      tx_data_q;
    logic            tx_valid_q;
    logic [1:0]      dbg_addr_q;
    logic [31:0]     dbg_din_q;
    logic            dbg_wr_en_q;
    logic            dbg_req_q;
    logic            busy_q;
    logic            overrun_q;

    logic [31:0]     word_d;
    logic            in_rx_state;

    // Little-endian shift: the newest byte enters at the top, so after four
    // bytes the first one received sits in [7:0].
    assign word_d      = {rx_data_i, word_q[31:8]};
    assign in_rx_state = (state_q == S_RX_CMD) || (state_q == S_RX_ADDR) ||
                         (state_q == S_RX_DATA);

    // Frame collection, mailbox writes, req/ack handshake and result transmit.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_RX_CMD;
            byte_cnt_q  <= 2'd0;
            to_cnt_q    <= '0;
            word_q      <= 32'd0;
            result_q    <= 32'd0;
            tx_data_q   <= 8'd0;
            tx_valid_q  <= 1'b0;
            dbg_addr_q  <= 2'd0;
            dbg_din_q   <= 32'd0;
            dbg_wr_en_q <= 1'b0;
            dbg_req_q   <= 1'b0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            dbg_wr_en_q <= 1'b0;

            // Bytes arriving while a transaction is in flight are dropped.
            if (rx_valid_i && !in_rx_state) begin
                overrun_q <= 1'b1;
            end

            case (state_q)
                S_RX_CMD: begin
                    to_cnt_q   <= '0;
                    byte_cnt_q <= 2'd0;
                    if (rx_valid_i) begin
                        dbg_addr_q  <= 2'd0;
                        dbg_din_q   <= {24'd0, rx_data_i};
                        dbg_wr_en_q <= 1'b1;
                        busy_q      <= 1'b1;
                        state_q     <= S_RX_ADDR;
                    end
                end

                S_RX_ADDR, S_RX_DATA: begin
                    // A byte in the same cycle as the timeout wins.
                    if (rx_valid_i) begin
                        to_cnt_q   <= '0;
                        word_q     <= word_d;
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                        if (byte_cnt_q == 2'd3) begin
                            dbg_din_q   <= word_d;
                            dbg_wr_en_q <= 1'b1;
                            if (state_q == S_RX_ADDR) begin
                                dbg_addr_q <= 2'd1;
                                state_q    <= S_RX_DATA;
                            end else begin
                                dbg_addr_q <= 2'd2;
                                state_q    <= S_WR_DATA;
                            end
                        end
                    end else if (to_cnt_q == TO_LAST) begin
                        // Partial frame abandoned; earlier word writes are
                        // simply overwritten by the next frame.
                        to_cnt_q   <= '0;
                        byte_cnt_q <= 2'd0;
                        busy_q     <= 1'b0;
                        state_q    <= S_RX_CMD;
                    end else begin
                        to_cnt_q <= to_cnt_q + TO_W'(1);
                    end
                end

                S_WR_DATA: begin
                    state_q <= S_REQ;
                end

                S_REQ: begin
                    // Never raise req on top of a stale ack (e.g. after a
                    // reset that interrupted the previous handshake).
                    if (!dbg_ack_i) begin
                        dbg_req_q <= 1'b1;
                        state_q   <= S_WAIT_ACK_HI;
                    end
                end

                S_WAIT_ACK_HI: begin
                    if (dbg_ack_i) begin
                        dbg_req_q  <= 1'b0;
                        dbg_addr_q <= 2'd3;
                        state_q    <= S_WAIT_ACK_LO;
                    end
                end

                S_WAIT_ACK_LO: begin
                    if (!dbg_ack_i) begin
                        state_q <= S_RD_RESULT;
                    end
                end

                S_RD_RESULT: begin
                    // Word 3 has been addressed for at least one cycle, so the
                    // registered mailbox output is valid here.
                    result_q   <= dbg_dout_i;
                    tx_data_q  <= dbg_dout_i[7:0];
                    tx_valid_q <= 1'b1;
                    byte_cnt_q <= 2'd0;
                    state_q    <= S_TX;
                end

                S_TX: begin
                    if (tx_valid_q && tx_ready_i) begin
                        if (byte_cnt_q == 2'd3) begin
                            tx_valid_q <= 1'b0;
                            busy_q     <= 1'b0;
                            byte_cnt_q <= 2'd0;
                            state_q    <= S_RX_CMD;
                        end else begin
                            byte_cnt_q <= byte_cnt_q + 2'd1;
                            result_q   <= {8'd0, result_q[31:8]};
                            tx_data_q  <= result_q[15:8];
                        end
                    end
                end

                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_RX_CMD;
                end
            endcase
        end
    end

    assign tx_data_o   = tx_data_q;
    assign tx_valid_o  = tx_valid_q;
    assign dbg_addr_o  = dbg_addr_q;
    assign dbg_din_o   = dbg_din_q;
    assign dbg_wr_en_o = dbg_wr_en_q;
    assign dbg_req_o   = dbg_req_q;
    assign busy_o      = busy_q;
    assign overrun_o   = overrun_q;

endmodule

// File: tb/tb_oldland_dbg_uart_bridge.sv
// Bench for oldland_dbg_uart_bridge: a mailbox/controller model answers the
// req/ack handshake, tasks drive frames and compare against frame-derived
// expectations.
module tb_oldland_dbg_uart_bridge;

    localparam int RX_TO = 40;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [1:0]  dbg_addr;
    logic [31:0] dbg_din;
    logic [31:0] dbg_dout;
    logic        dbg_wr_en;
    logic        dbg_req;
    logic        dbg_ack;
    logic        busy;
    logic        overrun;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    oldland_dbg_uart_bridge #(.RX_TIMEOUT(RX_TO)) dut (
        .clk_i(clk), .rst_i(rst),
        .rx_data_i(rx_data), .rx_valid_i(rx_valid),
        .tx_data_o(tx_data), .tx_valid_o(tx_valid), .tx_ready_i(tx_ready),
        .dbg_addr_o(dbg_addr), .dbg_din_o(dbg_din), .dbg_dout_i(dbg_dout),
        .dbg_wr_en_o(dbg_wr_en), .dbg_req_o(dbg_req), .dbg_ack_i(dbg_ack),
        .busy_o(busy), .overrun_o(overrun)
    );

    // Debug controller / mailbox model
    logic [31:0] mb [4];
    logic [31:0] snap_w [3];
    logic [31:0] resp_word = 32'd0;
    int          ack_delay = 1;
    int          ack_cnt = 0;
    int          req_rise_cnt = 0;
    int          req_ack_err = 0;
    int          wr_dup_err = 0;
    logic        prev_req = 1'b0;
    logic        prev_wr = 1'b0;

    initial begin
        for (int i = 0; i < 4; i++) mb[i] = 32'd0;
        for (int i = 0; i < 3; i++) snap_w[i] = 32'd0;
        dbg_ack  = 1'b0;
        dbg_dout = 32'd0;
    end

    always @(posedge clk) begin
        prev_req <= dbg_req;
        prev_wr  <= dbg_wr_en;
        dbg_dout <= mb[dbg_addr];
        if (dbg_wr_en) mb[dbg_addr] <= dbg_din;
        if (dbg_wr_en && prev_wr) wr_dup_err <= wr_dup_err + 1;
        if (dbg_req && !prev_req) begin
            req_rise_cnt <= req_rise_cnt + 1;
            if (dbg_ack) req_ack_err <= req_ack_err + 1;
            snap_w[0] <= mb[0];
            snap_w[1] <= mb[1];
            snap_w[2] <= mb[2];
        end
        if (dbg_req && !dbg_ack) begin
            if (ack_cnt >= ack_delay) begin
                dbg_ack <= 1'b1;
                ack_cnt <= 0;
                mb[3]   <= resp_word;
            end else ack_cnt <= ack_cnt + 1;
        end else if (!dbg_req && dbg_ack) begin
            if (ack_cnt >= ack_delay) begin
                dbg_ack <= 1'b0;
                ack_cnt <= 0;
            end else ack_cnt <= ack_cnt + 1;
        end else ack_cnt <= 0;
    end

    // Reference model: frame byte i (0 = cmd) and little-endian words from it
    function automatic logic [7:0] fbyte(input logic [71:0] f, input int i);
        return f[71-8*i -: 8];
    endfunction

    function automatic logic [31:0] le_word(input logic [71:0] f, input int first);
        return {fbyte(f, first+3), fbyte(f, first+2), fbyte(f, first+1), fbyte(f, first)};
    endfunction

    // Stimulus helpers (all start and end just after a falling edge)
    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_frame(input logic [71:0] f, input int min_gap, input int max_gap);
        for (int i = 0; i < 9; i++)
            send_byte(fbyte(f, i), (i == 8) ? 0 : int'($urandom_range(max_gap, min_gap)));
    endtask

    task automatic collect_tx(input int budget, input int ready_pct,
                              output logic [31:0] got, output int cnt);
        cnt = 0;
        got = 32'd0;
        for (int c = 0; c < budget && cnt < 4; c++) begin
            tx_ready = (int'($urandom_range(99, 0)) < ready_pct);
            if (tx_valid && tx_ready) begin
                got[8*cnt +: 8] = tx_data;
                cnt++;
            end
            @(negedge clk);
        end
        tx_ready = 1'b0;
    endtask

    task automatic wait_req(input int budget, output logic seen);
        for (int c = 0; c < budget; c++) begin
            if (dbg_req) break;
            @(negedge clk);
        end
        seen = dbg_req;
    endtask

    task automatic test_reset();
        rst = 1'b1; rx_valid = 1'b0; rx_data = 8'd0; tx_ready = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if ({tx_valid, dbg_wr_en, dbg_req, busy, overrun} !== 5'b0) begin
            n_err++; $display("FAIL reset_flags got=%b exp=00000", {tx_valid, dbg_wr_en, dbg_req, busy, overrun}); end
        n_cmp++; if ({tx_data, dbg_addr, dbg_din} !== 42'd0) begin
            n_err++; $display("FAIL reset_data got=%h exp=0", {tx_data, dbg_addr, dbg_din}); end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++; if ({busy, dbg_req, tx_valid} !== 3'b0) begin
            n_err++; $display("FAIL idle_after_reset got=%b exp=000", {busy, dbg_req, tx_valid}); end
        $display("test_reset done");
    endtask

    task automatic test_basic();
        logic [31:0] got; int cnt; int base;
        base = req_rise_cnt; resp_word = 32'h1234ABCD; ack_delay = 2;
        send_frame(72'h03_04000000_00000000, 0, 2);
        n_cmp++; if ({dbg_wr_en, dbg_addr, dbg_din} !== {1'b1, 2'd2, 32'd0}) begin
            n_err++; $display("FAIL w2_write_cycle got=%h exp=%h", {dbg_wr_en, dbg_addr, dbg_din}, {1'b1, 2'd2, 32'd0}); end
        @(negedge clk);
        n_cmp++; if ({dbg_req, dbg_wr_en} !== 2'b00) begin
            n_err++; $display("FAIL req_cycle2 got=%b exp=00", {dbg_req, dbg_wr_en}); end
        @(negedge clk);
        n_cmp++; if (dbg_req !== 1'b1) begin
            n_err++; $display("FAIL req_latency got=%b exp=1", dbg_req); end
        collect_tx(500, 100, got, cnt);
        n_cmp++; if (cnt !== 4 || got !== 32'h1234ABCD) begin
            n_err++; $display("FAIL basic_tx got=%0d bytes %h exp=4 bytes 1234abcd", cnt, got); end
        n_cmp++; if ({snap_w[0], snap_w[1], snap_w[2]} !== {32'd3, 32'd4, 32'd0}) begin
            n_err++; $display("FAIL basic_words got=%h %h %h exp=3 4 0", snap_w[0], snap_w[1], snap_w[2]); end
        n_cmp++; if (req_rise_cnt - base !== 1 || busy !== 1'b0) begin
            n_err++; $display("FAIL basic_req_count got=%0d busy=%b exp=1 busy=0", req_rise_cnt - base, busy); end
        $display("test_basic done tx=%h", got);
    endtask

    task automatic test_wmem();
        logic [31:0] got; int cnt; int base;
        base = req_rise_cnt; resp_word = $urandom; ack_delay = 3;
        send_frame(72'h08_00100000_EFBEADDE, 0, 5);
        collect_tx(500, 60, got, cnt);
        n_cmp++; if ({snap_w[0], snap_w[1], snap_w[2]} !== {32'd8, 32'h00001000, 32'hDEADBEEF}) begin
            n_err++; $display("FAIL wmem_words got=%h %h %h exp=8 00001000 deadbeef", snap_w[0], snap_w[1], snap_w[2]); end
        n_cmp++; if (cnt !== 4 || got !== resp_word || req_rise_cnt - base !== 1) begin
            n_err++; $display("FAIL wmem_tx got=%0d bytes %h reqs=%0d exp=4 bytes %h reqs=1", cnt, got, req_rise_cnt - base, resp_word); end
        $display("test_wmem done tx=%h", got);
    endtask

    task automatic test_timeout();
        logic [31:0] got; int cnt; int base; logic [71:0] f;
        base = req_rise_cnt; resp_word = $urandom; ack_delay = 1;
        send_byte(8'h05, 0);
        send_byte(8'h00, 0);
        n_cmp++; if (busy !== 1'b1) begin
            n_err++; $display("FAIL partial_busy got=%b exp=1", busy); end
        send_byte(8'h10, RX_TO);
        n_cmp++; if (busy !== 1'b0 || mb[1] !== 32'h00001000) begin
            n_err++; $display("FAIL timeout_drop got busy=%b w1=%h exp busy=0 w1=00001000", busy, mb[1]); end
        send_frame(72'h05_00200000_00000000, 0, 0);
        collect_tx(500, 100, got, cnt);
        n_cmp++; if (req_rise_cnt - base !== 1 || snap_w[1] !== 32'h00002000 || snap_w[0] !== 32'd5) begin
            n_err++; $display("FAIL timeout_frame got reqs=%0d w0=%h w1=%h exp reqs=1 w0=5 w1=00002000", req_rise_cnt - base, snap_w[0], snap_w[1]); end
        n_cmp++; if (cnt !== 4 || got !== resp_word) begin
            n_err++; $display("FAIL timeout_tx got=%0d bytes %h exp=4 bytes %h", cnt, got, resp_word); end
        // Every gap ends exactly on the timeout cycle: the byte must win.
        base = req_rise_cnt; resp_word = $urandom;
        f = {8'($urandom), 32'($urandom), 32'($urandom)};
        send_frame(f, RX_TO - 1, RX_TO - 1);
        collect_tx(500, 100, got, cnt);
        n_cmp++; if (req_rise_cnt - base !== 1 || snap_w[1] !== le_word(f, 1) || snap_w[2] !== le_word(f, 5)) begin
            n_err++; $display("FAIL timeout_edge got reqs=%0d w1=%h w2=%h exp reqs=1 w1=%h w2=%h", req_rise_cnt - base, snap_w[1], snap_w[2], le_word(f, 1), le_word(f, 5)); end
        $display("test_timeout done");
    endtask

    task automatic test_overrun();
        logic [31:0] got; int cnt; int base; logic seen; logic [71:0] f;
        base = req_rise_cnt; resp_word = $urandom; ack_delay = 15;
        f = {8'($urandom), 32'($urandom), 32'($urandom)};
        n_cmp++; if (overrun !== 1'b0) begin
            n_err++; $display("FAIL overrun_pre got=%b exp=0", overrun); end
        send_frame(f, 0, 2);
        wait_req(20, seen);
        n_cmp++; if (seen !== 1'b1) begin
            n_err++; $display("FAIL overrun_req_wait got=%b exp=1", seen); end
        send_byte(8'h55, 0);
        n_cmp++; if ({overrun, dbg_req} !== 2'b11) begin
            n_err++; $display("FAIL overrun_set got=%b exp=11", {overrun, dbg_req}); end
        collect_tx(500, 80, got, cnt);
        n_cmp++; if (cnt !== 4 || got !== resp_word || snap_w[2] !== le_word(f, 5)) begin
            n_err++; $display("FAIL overrun_tx got=%0d bytes %h w2=%h exp=4 bytes %h w2=%h", cnt, got, snap_w[2], resp_word, le_word(f, 5)); end
        repeat (20) @(negedge clk);
        n_cmp++; if (req_rise_cnt - base !== 1 || busy !== 1'b0) begin
            n_err++; $display("FAIL overrun_dropped got reqs=%0d busy=%b exp reqs=1 busy=0", req_rise_cnt - base, busy); end
        $display("test_overrun done tx=%h", got);
    endtask

    task automatic test_tx_stall();
        logic [7:0] exp_b; logic seen; logic [71:0] f;
        resp_word = $urandom; ack_delay = 1;
        f = {8'($urandom), 32'($urandom), 32'($urandom)};
        send_frame(f, 0, 1);
        for (int k = 0; k < 4; k++) begin
            exp_b = 8'(resp_word >> (8 * k));
            seen = 1'b0;
            for (int c = 0; c < 200; c++) begin
                if (tx_valid) begin seen = 1'b1; break; end
                @(negedge clk);
            end
            n_cmp++; if (seen !== 1'b1) begin
                n_err++; $display("FAIL stall_valid_wait byte%0d got=%b exp=1", k, seen); end
            for (int c = 0; c < 20; c++) begin
                n_cmp++; if (tx_valid !== 1'b1 || tx_data !== exp_b) begin
                    n_err++; $display("FAIL stall_hold byte%0d cyc%0d got=%b/%h exp=1/%h", k, c, tx_valid, tx_data, exp_b); end
                @(negedge clk);
            end
            tx_ready = 1'b1;
            @(negedge clk);
            tx_ready = 1'b0;
        end
        n_cmp++; if ({tx_valid, busy} !== 2'b00) begin
            n_err++; $display("FAIL stall_done got=%b exp=00", {tx_valid, busy}); end
        $display("test_tx_stall done");
    endtask

    task automatic test_reset_mid();
        logic [31:0] got; int cnt; int base; logic seen; logic [71:0] f;
        resp_word = $urandom; ack_delay = 30;
        f = {8'($urandom), 32'($urandom), 32'($urandom)};
        send_frame(f, 0, 1);
        wait_req(20, seen);
        n_cmp++; if ({seen, overrun} !== 2'b11) begin
            n_err++; $display("FAIL rstmid_pre got=%b exp=11", {seen, overrun}); end
        rst = 1'b1;
        @(negedge clk);
        n_cmp++; if ({dbg_req, busy, overrun, tx_valid} !== 4'b0000) begin
            n_err++; $display("FAIL rstmid_clear got=%b exp=0000", {dbg_req, busy, overrun, tx_valid}); end
        rst = 1'b0;
        @(negedge clk);
        base = req_rise_cnt; resp_word = $urandom; ack_delay = 3;
        f = {8'($urandom), 32'($urandom), 32'($urandom)};
        send_frame(f, 0, 3);
        collect_tx(500, 70, got, cnt);
        n_cmp++; if (cnt !== 4 || got !== resp_word || req_rise_cnt - base !== 1) begin
            n_err++; $display("FAIL rstmid_next got=%0d bytes %h reqs=%0d exp=4 bytes %h reqs=1", cnt, got, req_rise_cnt - base, resp_word); end
        n_cmp++; if (snap_w[0] !== {24'd0, fbyte(f, 0)} || snap_w[1] !== le_word(f, 1)) begin
            n_err++; $display("FAIL rstmid_words got=%h %h exp=%h %h", snap_w[0], snap_w[1], {24'd0, fbyte(f, 0)}, le_word(f, 1)); end
        $display("test_reset_mid done");
    endtask

    task automatic test_back_to_back();
        logic [31:0] got; int cnt; int base; logic [71:0] f;
        for (int n = 0; n < 6; n++) begin
            base = req_rise_cnt; resp_word = $urandom; ack_delay = int'($urandom_range(4, 0));
            f = {8'($urandom), 32'($urandom), 32'($urandom)};
            send_frame(f, 0, 3);
            collect_tx(500, 50, got, cnt);
            n_cmp++; if (snap_w[0] !== {24'd0, fbyte(f, 0)} || snap_w[1] !== le_word(f, 1) || snap_w[2] !== le_word(f, 5)) begin
                n_err++; $display("FAIL b2b_words frame%0d got=%h %h %h exp=%h %h %h", n, snap_w[0], snap_w[1], snap_w[2], {24'd0, fbyte(f, 0)}, le_word(f, 1), le_word(f, 5)); end
            n_cmp++; if (cnt !== 4 || got !== resp_word || req_rise_cnt - base !== 1) begin
                n_err++; $display("FAIL b2b_tx frame%0d got=%0d bytes %h reqs=%0d exp=4 bytes %h reqs=1", n, cnt, got, req_rise_cnt - base, resp_word); end
            $display("frame %0d cmd=%h addr=%h data=%h tx=%h", n, fbyte(f, 0), le_word(f, 1), le_word(f, 5), got);
        end
    endtask

    task automatic test_protocol_rules();
        n_cmp++; if (req_ack_err !== 0) begin
            n_err++; $display("FAIL req_while_ack got=%0d exp=0", req_ack_err); end
        n_cmp++; if (wr_dup_err !== 0) begin
            n_err++; $display("FAIL wr_en_multi_cycle got=%0d exp=0", wr_dup_err); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wmem();
        test_timeout();
        test_overrun();
        test_tx_stall();
        test_reset_mid();
        test_back_to_back();
        test_protocol_rules();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
